// File: rtl/fetch_unit.sv
// Single-slot instruction fetch stage feeding the IF/ID register.
// Optional bounds check and HALT state under FETCH_BOUNDS_CHECK_EN.
module fetch_unit #(
   parameter int MEM_SIZE = 1024
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect,
   input  logic [63:0] redirect_target,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [63:0] id_pc,
   output logic        fault
);

   if (MEM_SIZE <= 4 || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_bad_size
      $error("fetch_unit: MEM_SIZE must be a power of two above 4");
   end

   logic [63:0] pc;
   logic [63:0] tgt;
   logic        slot_free;

   assign imem_addr = pc;
   assign tgt       = redirect_target & ~64'd3;
   assign slot_free = !id_valid || id_ready;

`ifdef FETCH_BOUNDS_CHECK_EN
   typedef enum logic {RUN, HALT} state_t;

   localparam logic [63:0] LIMIT = 64'(MEM_SIZE);

   state_t state;
   logic   fault_q;
   logic   oob;

   // Last byte of the word at pc must lie inside memory.
   assign oob   = (pc + 64'd3) >= LIMIT;
   assign fault = fault_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         pc       <= '0;
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc    <= '0;
         fault_q  <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (redirect) begin
                  pc       <= tgt;
                  id_valid <= 1'b0;
               end else if (slot_free) begin
                  if (oob) begin
                     state    <= HALT;
                     id_valid <= 1'b0;
                     fault_q  <= 1'b1;
                  end else begin
                     id_instr <= imem_instr;
                     id_pc    <= pc;
                     id_valid <= 1'b1;
                     pc       <= pc + 64'd4;
                  end
               end
            end
            HALT: begin
               id_valid <= 1'b0;
               fault_q  <= 1'b1;
            end
            default: state <= RUN;
         endcase
      end
   end
`else
   assign fault = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= '0;
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc    <= '0;
      end else if (redirect) begin
         pc       <= tgt;
         id_valid <= 1'b0;
      end else if (slot_free) begin
         id_instr <= imem_instr;
         id_pc    <= pc;
         id_valid <= 1'b1;
         pc       <= pc + 64'd4;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; ROM word at address a is
// 32'hC000_0000 | (a[31:0] >> 2).
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect;
   logic [63:0] redirect_target;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [63:0] id_pc;
   logic        fault;

   int tests;
   int fails;

   fetch_unit #(.MEM_SIZE(1024)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .id_ready        (id_ready),
      .id_valid        (id_valid),
      .id_instr        (id_instr),
      .id_pc           (id_pc),
      .fault           (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_instr = 32'hC000_0000 | (imem_addr[31:0] >> 2);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      redirect = 1'b0;
      id_ready = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset           = 1'b1;
      redirect        = 1'b1;
      redirect_target = 64'h40;
      id_ready        = 1'b1;
      step();
      tests++;
      if (imem_addr !== 64'd0) begin
         fails++;
         $display("FAIL reset_pc got %h want 0", imem_addr);
      end
      tests++;
      if (id_valid !== 1'b0 || id_instr !== 32'd0 || id_pc !== 64'd0) begin
         fails++;
         $display("FAIL reset_slot got v=%b i=%h p=%h want 0/0/0",
                  id_valid, id_instr, id_pc);
      end
      tests++;
      if (fault !== 1'b0) begin
         fails++;
         $display("FAIL reset_fault got %b want 0", fault);
      end
      reset    = 1'b0;
      redirect = 1'b0;
   endtask

   task automatic test_stream();
      logic [63:0] pcs [4];
      logic [31:0] ins [4];
      pcs = '{64'd0, 64'd4, 64'd8, 64'd12};
      ins = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003};
      do_reset();
      id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         tests++;
         if (id_valid !== 1'b1 || id_pc !== pcs[i] || id_instr !== ins[i]) begin
            fails++;
            $display("FAIL stream[%0d] got v=%b p=%h i=%h want 1/%h/%h",
                     i, id_valid, id_pc, id_instr, pcs[i], ins[i]);
         end
      end
      tests++;
      if (imem_addr !== 64'd16) begin
         fails++;
         $display("FAIL stream_addr got %h want 10", imem_addr);
      end
   endtask

   task automatic test_stall();
      do_reset();
      id_ready = 1'b1;
      step();
      step();
      step();
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++;
         if (id_valid !== 1'b1 || id_pc !== 64'd8 || imem_addr !== 64'd12
             || id_instr !== 32'hC000_0002) begin
            fails++;
            $display("FAIL stall[%0d] got v=%b p=%h a=%h i=%h want 1/8/c/c0000002",
                     i, id_valid, id_pc, imem_addr, id_instr);
         end
      end
      id_ready = 1'b1;
      step();
      tests++;
      if (id_valid !== 1'b1 || id_pc !== 64'd12 || imem_addr !== 64'd16) begin
         fails++;
         $display("FAIL stall_release got v=%b p=%h a=%h want 1/c/10",
                  id_valid, id_pc, imem_addr);
      end
   endtask

   task automatic test_redirect();
      id_ready        = 1'b1;
      redirect        = 1'b1;
      redirect_target = 64'h23;
      step();
      tests++;
      if (id_valid !== 1'b0 || imem_addr !== 64'h20) begin
         fails++;
         $display("FAIL redirect_flush got v=%b a=%h want 0/20",
                  id_valid, imem_addr);
      end
      redirect = 1'b0;
      step();
      tests++;
      if (id_valid !== 1'b1 || id_pc !== 64'h20 || id_instr !== 32'hC000_0008
          || imem_addr !== 64'h24) begin
         fails++;
         $display("FAIL redirect_capture got v=%b p=%h i=%h a=%h want 1/20/c0000008/24",
                  id_valid, id_pc, id_instr, imem_addr);
      end
      id_ready        = 1'b0;
      redirect        = 1'b1;
      redirect_target = 64'h100;
      step();
      tests++;
      if (id_valid !== 1'b0 || imem_addr !== 64'h100 || id_pc !== 64'h20) begin
         fails++;
         $display("FAIL redirect_stalled got v=%b a=%h p=%h want 0/100/20",
                  id_valid, imem_addr, id_pc);
      end
      redirect = 1'b0;
      step();
      tests++;
      if (id_valid !== 1'b1 || id_pc !== 64'h100 || imem_addr !== 64'h104) begin
         fails++;
         $display("FAIL empty_slot_capture got v=%b p=%h a=%h want 1/100/104",
                  id_valid, id_pc, imem_addr);
      end
   endtask

`ifndef FETCH_BOUNDS_CHECK_EN
   task automatic test_wrap();
      id_ready        = 1'b1;
      redirect        = 1'b1;
      redirect_target = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      tests++;
      if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         fails++;
         $display("FAIL wrap_target got %h want fffffffffffffffc", imem_addr);
      end
      redirect = 1'b0;
      step();
      tests++;
      if (imem_addr !== 64'd0 || id_pc !== 64'hFFFF_FFFF_FFFF_FFFC
          || id_instr !== 32'hFFFF_FFFF || fault !== 1'b0) begin
         fails++;
         $display("FAIL wrap got a=%h p=%h i=%h f=%b want 0/fffffffffffffffc/ffffffff/0",
                  imem_addr, id_pc, id_instr, fault);
      end
   endtask
`else
   task automatic test_bounds();
      do_reset();
      id_ready        = 1'b1;
      redirect        = 1'b1;
      redirect_target = 64'd1020;
      step();
      redirect = 1'b0;
      step();
      tests++;
      if (id_valid !== 1'b1 || id_pc !== 64'd1020 || imem_addr !== 64'd1024) begin
         fails++;
         $display("FAIL bounds_last got v=%b p=%h a=%h want 1/3fc/400",
                  id_valid, id_pc, imem_addr);
      end
      step();
      tests++;
      if (fault !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 64'd1024) begin
         fails++;
         $display("FAIL bounds_halt got f=%b v=%b a=%h want 1/0/400",
                  fault, id_valid, imem_addr);
      end
      redirect        = 1'b1;
      redirect_target = 64'd0;
      step();
      tests++;
      if (fault !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 64'd1024) begin
         fails++;
         $display("FAIL halt_ignore got f=%b v=%b a=%h want 1/0/400",
                  fault, id_valid, imem_addr);
      end
      redirect = 1'b0;
      reset    = 1'b1;
      step();
      reset = 1'b0;
      tests++;
      if (fault !== 1'b0 || imem_addr !== 64'd0) begin
         fails++;
         $display("FAIL halt_reset got f=%b a=%h want 0/0", fault, imem_addr);
      end
   endtask
`endif

   task automatic test_reset_stall();
      do_reset();
      id_ready = 1'b1;
      step();
      step();
      id_ready = 1'b0;
      step();
      reset           = 1'b1;
      redirect        = 1'b1;
      redirect_target = 64'h80;
      step();
      reset    = 1'b0;
      redirect = 1'b0;
      tests++;
      if (id_valid !== 1'b0 || imem_addr !== 64'd0 || fault !== 1'b0
          || id_pc !== 64'd0) begin
         fails++;
         $display("FAIL reset_stall got v=%b a=%h f=%b p=%h want 0/0/0/0",
                  id_valid, imem_addr, fault, id_pc);
      end
      step();
      tests++;
      if (id_valid !== 1'b1 || id_pc !== 64'd0 || id_instr !== 32'hC000_0000) begin
         fails++;
         $display("FAIL first_after_reset got v=%b p=%h i=%h want 1/0/c0000000",
                  id_valid, id_pc, id_instr);
      end
   endtask

   initial begin
      tests           = 0;
      fails           = 0;
      reset           = 1'b1;
      redirect        = 1'b0;
      redirect_target = 64'd0;
      id_ready        = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
`ifndef FETCH_BOUNDS_CHECK_EN
      test_wrap();
`else
      test_bounds();
`endif
      test_reset_stall();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
